// File: rtl/aes_inv_key_sched_if.sv
// Handshake bundle between the inverse key schedule and its controller/consumer.
// The master drives control and ready; the slave (the schedule) returns round keys.
interface aes_inv_key_sched_if;
    logic         start;
    logic         abort;
    logic [127:0] key_in;
    logic         rk_ready;
    logic         rk_valid;
    logic [127:0] rk_out;
    logic [3:0]   rk_round;
    logic         busy;
    logic         done;

    modport master (
        output start, abort, key_in, rk_ready,
        input  rk_valid, rk_out, rk_round, busy, done
    );

    modport slave (
        input  start, abort, key_in, rk_ready,
        output rk_valid, rk_out, rk_round, busy, done
    );
endinterface

// File: rtl/aes_inv_key_sched.sv
// Iterative inverse AES-128 key schedule: loads the round-NR key and streams
// round keys NR..0 backwards, one per accepted valid/ready handshake.
module aes_inv_key_sched #(
    parameter int NR = 10
) (
    input  logic                clk,
    input  logic                rst,
    aes_inv_key_sched_if.slave  bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0x00 sits in the top byte, so byte x starts at bit (255-x)*8.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] k);
        case (k)
            4'd0:    return 8'h01;
            4'd1:    return 8'h02;
            4'd2:    return 8'h04;
            4'd3:    return 8'h08;
            4'd4:    return 8'h10;
            4'd5:    return 8'h20;
            4'd6:    return 8'h40;
            4'd7:    return 8'h80;
            4'd8:    return 8'h1b;
            4'd9:    return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    state_t         state_q,    state_d;
    logic [127:0]   rk_out_q,   rk_out_d;
    logic [3:0]     rk_round_q, rk_round_d;

    logic [31:0]    w0, w1, w2, w3;
    logic [31:0]    p0, p1, p2, p3;
    logic [127:0]   inv_key;

    // Undo one forward expansion step; p3 is the previous key's last word.
    always_comb begin
        {w0, w1, w2, w3} = rk_out_q;
        p3      = w3 ^ w2;
        p2      = w2 ^ w1;
        p1      = w1 ^ w0;
        p0      = w0 ^ sub_word({p3[23:0], p3[31:24]})
                     ^ {rcon(rk_round_q - 4'd1), 24'h000000};
        inv_key = {p0, p1, p2, p3};
    end

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch can be inferred.
        state_d    = state_q;
        rk_out_d   = rk_out_q;
        rk_round_d = rk_round_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    rk_out_d   = bus.key_in;
                    rk_round_d = 4'(NR);
                    state_d    = S_EMIT;
                end
            end
            S_EMIT: begin
                if (bus.abort) begin
                    state_d = S_IDLE;
                end else if (bus.rk_ready) begin
                    if (rk_round_q == 4'd0) begin
                        state_d = S_DONE;
                    end else begin
                        rk_out_d   = inv_key;
                        rk_round_d = rk_round_q - 4'd1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: the key register is reset too, so rk_out reads zero immediately
    // on rst rather than leaking the last key schedule to the consumer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rk_out_q   <= '0;
            rk_round_q <= '0;
        end else begin
            state_q    <= state_d;
            rk_out_q   <= rk_out_d;
            rk_round_q <= rk_round_d;
        end
    end

    assign bus.rk_valid = (state_q == S_EMIT);
    assign bus.busy     = (state_q == S_EMIT);
    assign bus.done     = (state_q == S_DONE);
    assign bus.rk_out   = rk_out_q;
    assign bus.rk_round = rk_round_q;

endmodule

// File: tb/tb_aes_inv_key_sched.sv
// Self-checking bench for aes_inv_key_sched: the reference is a forward AES-128
// key expansion with an S-box derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    aes_inv_key_sched_if bus ();

    aes_inv_key_sched #(.NR(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    logic [7:0]   sbox_ref [0:255];
    logic [127:0] exp_keys [0:10];
    logic [127:0] got      [0:10];

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc = 8'h00;
        logic [7:0] aa  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ aa;
            aa = xtime(aa);
        end
        return acc;
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            logic [7:0] b;
            for (int y = 1; y < 256; y++)
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            b = inv;
            sbox_ref[x] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                            ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
        end
    endtask

    // Standard forward key expansion from the cipher key (round 0).
    task automatic expand(input logic [127:0] k0);
        logic [31:0] w [0:43];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        {w[0], w[1], w[2], w[3]} = k0;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_ref[t[31:24]], sbox_ref[t[23:16]], sbox_ref[t[15:8]], sbox_ref[t[7:0]]};
                t = t ^ {rc, 24'h0};
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++)
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic load_key(input logic [127:0] k);
        bus.key_in = k;
        bus.start  = 1'b1;
        @(negedge clk);
        bus.start  = 1'b0;
        bus.key_in = ~k;
    endtask

    // Walks the stream from round 10; stop_at >= 0 returns once that round is showing.
    task automatic stream_check(input string name, input bit random_ready,
                                input int stop_at, input bit poke_start);
        int exp_r    = 10;
        int cycles   = 0;
        bit finished = 1'b0;
        bit ready;
        while (!finished && cycles < 200) begin
            if (exp_r == stop_at) break;
            checks++;
            if (bus.rk_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0 ||
                bus.rk_round !== 4'(exp_r) || bus.rk_out !== exp_keys[exp_r]) begin
                errors++;
                $display("FAIL %s key r%0d: valid=%b busy=%b done=%b round=%0d out=%h, expected valid=1 busy=1 done=0 round=%0d out=%h",
                         name, exp_r, bus.rk_valid, bus.busy, bus.done, bus.rk_round,
                         bus.rk_out, exp_r, exp_keys[exp_r]);
            end
            ready        = random_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            bus.rk_ready = ready;
            if (poke_start) begin
                bus.start  = (cycles == 3);
                bus.key_in = {$urandom, $urandom, $urandom, $urandom};
            end
            if (ready) got[exp_r] = bus.rk_out;
            @(negedge clk);
            bus.start = 1'b0;
            cycles++;
            if (ready) begin
                if (exp_r == 0) finished = 1'b1;
                else exp_r--;
            end
        end
        if (stop_at >= 0 ? (exp_r != stop_at) : !finished) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: reached round %0d after %0d cycles, expected stream end", name, exp_r, cycles);
            return;
        end
        if (stop_at >= 0) return;
        checks++;
        if (bus.done !== 1'b1 || bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.rk_out !== exp_keys[0]) begin
            errors++;
            $display("FAIL %s done pulse: done=%b valid=%b busy=%b out=%h, expected done=1 valid=0 busy=0 out=%h",
                     name, bus.done, bus.rk_valid, bus.busy, bus.rk_out, exp_keys[0]);
        end
        bus.rk_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0 || bus.rk_out !== exp_keys[0]) begin
            errors++;
            $display("FAIL %s after done: done=%b valid=%b out=%h, expected done=0 valid=0 out=%h",
                     name, bus.done, bus.rk_valid, bus.rk_out, exp_keys[0]);
        end
    endtask

    task automatic check_zero(input string name);
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rk_out !== 128'h0 || bus.rk_round !== 4'h0) begin
            errors++;
            $display("FAIL %s: valid=%b busy=%b done=%b round=%0d out=%h, expected all zero",
                     name, bus.rk_valid, bus.busy, bus.done, bus.rk_round, bus.rk_out);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);
        check_zero("idle_after_reset");
    endtask

    task automatic test_fips();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        stream_check("fips", 1'b0, -1, 1'b0);
        checks++;
        if (got[9] !== 128'hac7766f319fadc2128d12941575c006e ||
            got[1] !== 128'ha0fafe1788542cb123a339392a6c7605 ||
            got[0] !== 128'h2b7e151628aed2a6abf7158809cf4f3c) begin
            errors++;
            $display("FAIL fips_vectors: r9=%h r1=%h r0=%h, expected ac7766f3.. a0fafe17.. 2b7e1516..",
                     got[9], got[1], got[0]);
        end
    endtask

    task automatic test_stall();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(exp_keys[10]);
        stream_check("stall", 1'b1, -1, 1'b0);
    endtask

    task automatic test_start_busy();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(exp_keys[10]);
        stream_check("start_busy", 1'b1, -1, 1'b1);
    endtask

    task automatic test_start_abort_idle();
        expand(128'h000102030405060708090a0b0c0d0e0f);
        bus.abort = 1'b1;
        load_key(exp_keys[10]);
        bus.abort = 1'b0;
        stream_check("start_abort_idle", 1'b0, -1, 1'b0);
    endtask

    task automatic test_abort();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(exp_keys[10]);
        stream_check("abort_pre", 1'b0, 5, 1'b0);
        bus.abort    = 1'b1;
        bus.rk_ready = 1'b1;
        @(negedge clk);
        bus.abort    = 1'b0;
        bus.rk_ready = 1'b0;
        checks++;
        if (bus.rk_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
            bus.rk_round !== 4'd5 || bus.rk_out !== exp_keys[5]) begin
            errors++;
            $display("FAIL abort_hold: valid=%b busy=%b done=%b round=%0d out=%h, expected 0 0 0 round=5 out=%h",
                     bus.rk_valid, bus.busy, bus.done, bus.rk_round, bus.rk_out, exp_keys[5]);
        end
        @(negedge clk);
        checks++;
        if (bus.done !== 1'b0 || bus.rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: done=%b valid=%b, expected done=0 valid=0", bus.done, bus.rk_valid);
        end
        load_key(exp_keys[10]);
        stream_check("abort_restart", 1'b0, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        expand(128'h2b7e151628aed2a6abf7158809cf4f3c);
        load_key(exp_keys[10]);
        bus.rk_ready = 1'b1;
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_zero("async_reset_mid");
        @(negedge clk);
        rst          = 1'b0;
        bus.rk_ready = 1'b0;
        @(negedge clk);
        check_zero("idle_after_mid_reset");
        load_key(exp_keys[10]);
        stream_check("after_reset", 1'b0, -1, 1'b0);
    endtask

    task automatic test_random_keys();
        for (int n = 0; n < 4; n++) begin
            expand({$urandom, $urandom, $urandom, $urandom});
            load_key(exp_keys[10]);
            stream_check("random_key", 1'b1, -1, 1'b0);
        end
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.key_in   = '0;
        bus.rk_ready = 1'b0;
        build_sbox();
        test_reset();
        test_fips();
        test_stall();
        test_start_busy();
        test_start_abort_idle();
        test_abort();
        test_reset_mid();
        test_random_keys();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
